// File: rtl/queue_pop_mux.sv
// queue_pop_mux: pops the arbiter-granted queue and buffers the 1-cycle-latency word for egress.
// Define SERVE_COUNT_EN to add the per-queue saturating served_cnt counters.
module queue_pop_mux #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          selector,
  input  logic                                out_enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic                                rr_enb,
  output logic [DATA_BITS-1:0]                data_out,
  output logic [1:0]                          data_out_src,
  output logic                                data_out_valid,
  input  logic                                dst_ready
`ifdef SERVE_COUNT_EN
  ,
  output logic [QUEUE_QUANTITY*8-1:0]         served_cnt
`endif
);

  logic                 pend_valid_r;
  logic [1:0]           pend_src_r;
  logic [1:0]           count_r;
  logic                 head_r;
  logic                 tail_r;
  logic [DATA_BITS-1:0] mem_data_r [2];
  logic [1:0]           mem_src_r [2];

  logic                 deq_s;
  logic                 credit_s;
  logic                 fire_s;
  logic [2:0]           occ_s;
  logic [DATA_BITS-1:0] wr_data_s;

  assign data_out_valid = (count_r != 2'd0);
  assign data_out       = mem_data_r[head_r];
  assign data_out_src   = mem_src_r[head_r];

  // Credit counts the in-flight pend word as occupied so the 2-entry buffer never overflows.
  always_comb begin
    deq_s     = data_out_valid && dst_ready;
    occ_s     = {1'b0, count_r} + {2'b00, pend_valid_r};
    credit_s  = (occ_s < (3'd2 + {2'b00, deq_s}));
    fire_s    = out_enb && credit_s && !buf_empty[selector] && !rst;
    rr_enb    = credit_s && !rst;
    wr_data_s = fifo_data[int'(pend_src_r)*DATA_BITS +: DATA_BITS];
    if (fire_s) begin
      pop = {{(QUEUE_QUANTITY-1){1'b0}}, 1'b1} << selector;
    end else begin
      pop = {QUEUE_QUANTITY{1'b0}};
    end
  end

  // Pop pipeline stage and 2-entry output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_r <= 1'b0;
      pend_src_r   <= 2'd0;
      count_r      <= 2'd0;
      head_r       <= 1'b0;
      tail_r       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_data_r[i] <= {DATA_BITS{1'b0}};
        mem_src_r[i]  <= 2'd0;
      end
    end else begin
      pend_valid_r <= fire_s;
      pend_src_r   <= selector;
      if (pend_valid_r) begin
        mem_data_r[tail_r] <= wr_data_s;
        mem_src_r[tail_r]  <= pend_src_r;
        tail_r             <= ~tail_r;
      end
      if (deq_s) begin
        head_r <= ~head_r;
      end
      case ({pend_valid_r, deq_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef SERVE_COUNT_EN
  logic [7:0] cnt_r [QUEUE_QUANTITY];

  // Saturating per-source count of words handed to the egress consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < QUEUE_QUANTITY; q++) begin
        cnt_r[q] <= 8'd0;
      end
    end else if (deq_s && (cnt_r[data_out_src] != 8'hFF)) begin
      cnt_r[data_out_src] <= cnt_r[data_out_src] + 8'd1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    for (int q = 0; q < QUEUE_QUANTITY; q++) begin
      served_cnt[q*8 +: 8] = cnt_r[q];
    end
  end
`endif

endmodule

// File: tb/tb_queue_pop_mux.sv
// Self-checking bench for queue_pop_mux: directed phases then random traffic, all
// checked against a queue-based model of the FIFO bank and of the expected egress stream.
module tb_queue_pop_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  selector;
  logic        out_enb;
  logic [3:0]  buf_empty;
  logic [31:0] fifo_data;
  logic [3:0]  pop;
  logic        rr_enb;
  logic [7:0]  data_out;
  logic [1:0]  data_out_src;
  logic        data_out_valid;
  logic        dst_ready;
`ifdef SERVE_COUNT_EN
  logic [31:0] served_cnt;
`endif

  queue_pop_mux #(.QUEUE_QUANTITY(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .selector(selector), .out_enb(out_enb),
    .buf_empty(buf_empty), .fifo_data(fifo_data), .pop(pop), .rr_enb(rr_enb),
    .data_out(data_out), .data_out_src(data_out_src), .data_out_valid(data_out_valid),
    .dst_ready(dst_ready)
`ifdef SERVE_COUNT_EN
    , .served_cnt(served_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
    int         rdy;
  } ent_t;

  logic [7:0] envq [4][$];
  ent_t       expq[$];
  int         cnt_m [4];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         pops_seen = 0;
  int         p0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: check outputs against the model, advance the clock, update the model.
  task automatic tick();
    logic       vld_e;
    logic       deq_e;
    logic       rr_e;
    logic [3:0] pop_e;
    logic [7:0] w;
    int         osz;
    for (int q = 0; q < 4; q++) buf_empty[q] = (envq[q].size() == 0);
    #1;
    vld_e = (expq.size() > 0) && (expq[0].rdy <= cyc);
    deq_e = vld_e && dst_ready;
    osz   = expq.size() - (deq_e ? 1 : 0);
    rr_e  = !rst && (osz < 2);
    pop_e = (rr_e && out_enb && !buf_empty[selector]) ? (4'b0001 << selector) : 4'b0000;
    chk("pop", {28'd0, pop}, {28'd0, pop_e});
    chk("rr_enb", {31'd0, rr_enb}, {31'd0, rr_e});
    chk("valid", {31'd0, data_out_valid}, {31'd0, vld_e});
    if (vld_e) begin
      chk("data", {24'd0, data_out}, {24'd0, expq[0].data});
      chk("src", {30'd0, data_out_src}, {30'd0, expq[0].src});
    end
`ifdef SERVE_COUNT_EN
    for (int q = 0; q < 4; q++) chk("served", {24'd0, served_cnt[q*8 +: 8]}, cnt_m[q]);
`endif
    if (pop != 4'b0000) pops_seen++;
    @(posedge clk);
    #1;
    cyc++;
    fifo_data = $urandom();
    if (rst) begin
      expq.delete();
      for (int q = 0; q < 4; q++) cnt_m[q] = 0;
    end else begin
      if (deq_e) begin
        if (cnt_m[expq[0].src] < 255) cnt_m[expq[0].src]++;
        void'(expq.pop_front());
      end
      if (pop_e != 4'b0000) begin
        w = envq[selector].pop_front();
        fifo_data[int'(selector)*8 +: 8] = w;
        expq.push_back('{src: selector, data: w, rdy: cyc + 1});
      end
    end
  endtask

  task automatic clear_env();
    for (int q = 0; q < 4; q++) envq[q].delete();
  endtask

  initial begin
    for (int q = 0; q < 4; q++) cnt_m[q] = 0;
    rst = 1'b1; out_enb = 1'b1; selector = 2'd0; dst_ready = 1'b0;
    fifo_data = 32'd0; buf_empty = 4'b0000;
    @(posedge clk);
    #1;

    // Reset hold with all queues non-empty and a grant asserted.
    for (int q = 0; q < 4; q++) envq[q].push_back(8'h5A);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_src", {30'd0, data_out_src}, 32'd0);
    clear_env();

    // Single pop from queue 2.
    rst = 1'b0; out_enb = 1'b0; dst_ready = 1'b1;
    tick();
    envq[2].push_back(8'hA5);
    selector = 2'd2; out_enb = 1'b1;
    p0 = pops_seen;
    tick();
    chk("single_pops", pops_seen - p0, 32'd1);
    out_enb = 1'b0;
    tick();
    chk("single_data", {24'd0, data_out}, 32'h0000_00A5);
    chk("single_src", {30'd0, data_out_src}, 32'd2);
    chk("single_valid", {31'd0, data_out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) tick();

    // Streaming rotation over all four queues.
    envq[0].push_back(8'h10); envq[1].push_back(8'h21);
    envq[2].push_back(8'h32); envq[3].push_back(8'h43);
    out_enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      selector = 2'(i);
      tick();
    end
    out_enb = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Back-pressure: only two words may be in flight.
    for (int q = 0; q < 4; q++) for (int k = 0; k < 3; k++) envq[q].push_back(8'(8'hB0 + 8'(q*16 + k)));
    dst_ready = 1'b0; out_enb = 1'b1;
    p0 = pops_seen;
    for (int i = 0; i < 6; i++) begin
      selector = 2'(i);
      tick();
    end
    chk("bp_pops", pops_seen - p0, 32'd2);
    chk("bp_head", {24'd0, data_out}, 32'h0000_00B0);
    out_enb = 1'b0; dst_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_rr_back", {31'd0, rr_enb}, 32'd1);
    clear_env();

    // Grant to an empty queue, then to a non-empty one.
    envq[1].push_back(8'h77);
    out_enb = 1'b1; selector = 2'd0;
    p0 = pops_seen;
    tick();
    chk("empty_nopop", pops_seen - p0, 32'd0);
    selector = 2'd1;
    tick();
    out_enb = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Reset with a pop in flight.
    envq[3].push_back(8'hEE);
    out_enb = 1'b1; selector = 2'd3;
    tick();
    out_enb = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_valid", {31'd0, data_out_valid}, 32'd0);
    end

    // Long stream from queue 0 to drive its counter into saturation.
    for (int k = 0; k < 300; k++) envq[0].push_back(8'($urandom()));
    out_enb = 1'b1; selector = 2'd0; dst_ready = 1'b1;
    for (int i = 0; i < 305; i++) tick();
    out_enb = 1'b0;
    for (int i = 0; i < 3; i++) tick();
`ifdef SERVE_COUNT_EN
    chk("sat_cnt0", {24'd0, served_cnt[7:0]}, 32'd255);
`endif

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      for (int q = 0; q < 4; q++)
        if (envq[q].size() < 2 && $urandom_range(0, 2) == 0) envq[q].push_back(8'($urandom()));
      rst       = ($urandom_range(0, 99) == 0);
      out_enb   = ($urandom_range(0, 3) != 0);
      selector  = 2'($urandom_range(0, 3));
      dst_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
